// File: rtl/ccip_rd_stream_if.sv
// CCI-P c0 read request/response bundle and the reordered 512-bit output stream.
// master = read initiator, slave = host plus stream consumer.
interface ccip_rd_stream_if #(
   parameter int ADDR_W = 42
);
   logic              c0_tx_valid;
   logic [ADDR_W-1:0] c0_tx_addr;
   logic [15:0]       c0_tx_mdata;
   logic              c0_tx_almfull;
   logic              c0_rx_rdvalid;
   logic [15:0]       c0_rx_mdata;
   logic [511:0]      c0_rx_data;
   logic              out_valid;
   logic [511:0]      out_data;
   logic              out_ready;

   modport master (
      output c0_tx_valid, c0_tx_addr, c0_tx_mdata,
      input  c0_tx_almfull,
      input  c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
      output out_valid, out_data,
      input  out_ready
   );

   modport slave (
      input  c0_tx_valid, c0_tx_addr, c0_tx_mdata,
      output c0_tx_almfull,
      output c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
      input  out_valid, out_data,
      output out_ready
   );
endinterface

// File: rtl/ccip_rd_stream.sv
// Host-memory line fetcher on CCI-P c0: tagged reads, reorder buffer,
// in-order valid/ready stream of 512-bit lines.
module ccip_rd_stream #(
   parameter int TAG_W  = 4,
   parameter int ADDR_W = 42,
   parameter int LEN_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_lines,
   output logic              busy,
   output logic              done,
   ccip_rd_stream_if.master  bus
);
   localparam int DEPTH = 1 << TAG_W;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  num;
   logic [LEN_W-1:0]  issue_idx;
   logic [LEN_W-1:0]  retired;
   logic [TAG_W:0]    outst;
   logic [TAG_W-1:0]  head;
   logic [DEPTH-1:0]  slot_vld;
   logic [511:0]      mem [DEPTH];

   logic              rx_v;
   logic [TAG_W-1:0]  rx_tag;
   logic [511:0]      rx_data;

   logic              issue;
   logic              pop;
   logic              byp;
   logic              head_rdy;
   logic              load;
   logic              rx_set;
   logic              active;
   logic              accept;
   logic [511:0]      head_data;

   assign active   = (state == ISSUE) || (state == DRAIN);
   assign accept   = (state == IDLE) && start;
   assign pop      = bus.out_valid && bus.out_ready;
   // outst never exceeds DEPTH, so its top bit means "credits exhausted"
   assign issue    = (state == ISSUE) && !bus.c0_tx_almfull && !outst[TAG_W];
   // a response to the head slot can go straight to the output register
   assign byp      = rx_v && (rx_tag == head);
   assign head_rdy = slot_vld[head] || byp;
   assign head_data = slot_vld[head] ? mem[head] : rx_data;
   assign load     = head_rdy && (!bus.out_valid || bus.out_ready);
   assign rx_set   = rx_v && !(load && byp);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         base            <= '0;
         num             <= '0;
         issue_idx       <= '0;
         bus.c0_tx_valid <= 1'b0;
         bus.c0_tx_addr  <= '0;
         bus.c0_tx_mdata <= '0;
      end else begin
         done            <= 1'b0;
         bus.c0_tx_valid <= issue;
         if (issue) begin
            bus.c0_tx_addr  <= base + ADDR_W'(issue_idx);
            bus.c0_tx_mdata <= {{(16-TAG_W){1'b0}}, issue_idx[TAG_W-1:0]};
            issue_idx       <= issue_idx + 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  base      <= base_addr;
                  num       <= num_lines;
                  issue_idx <= '0;
                  busy      <= 1'b1;
                  if (num_lines == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (issue && (issue_idx == num - 1'b1)) state <= DRAIN;
            end
            DRAIN: begin
               if (retired == num) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // responses are registered; foreign tags and idle-time stragglers are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_v    <= 1'b0;
         rx_tag  <= '0;
         rx_data <= '0;
      end else begin
         rx_v    <= bus.c0_rx_rdvalid && active &&
                    (bus.c0_rx_mdata[15:TAG_W] == '0);
         rx_tag  <= bus.c0_rx_mdata[TAG_W-1:0];
         rx_data <= bus.c0_rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_v) mem[rx_tag] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_vld      <= '0;
         head          <= '0;
         outst         <= '0;
         retired       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         outst <= outst + (TAG_W+1)'(issue) - (TAG_W+1)'(pop);
         if (load) begin
            slot_vld[head] <= 1'b0;
            head           <= head + 1'b1;
            bus.out_valid  <= 1'b1;
            bus.out_data   <= head_data;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (rx_set) slot_vld[rx_tag] <= 1'b1;
         if (accept) begin
            retired <= '0;
            head    <= '0;
         end else if (pop) begin
            retired <= retired + 1'b1;
         end
      end
   end
endmodule
